// File: rtl/vkey_pkg.sv
// vkey_pkg: shared definitions for the key-event reader.
//   state_t            - event-qualifier FSM encoding
//   NUM_COLS, KNOB_ROW - keypad geometry (row 7 is the rotary encoder)
//   CODE_W             - width of a queued key code
//   DEF_DEPTH          - default key-event FIFO depth
//   DEF_FILT_LEN       - default INT low-filter length in CLK cycles
//   key_code()         - row/column to linear key code
package vkey_pkg;

    localparam int NUM_COLS     = 5;
    localparam int KNOB_ROW     = 7;
    localparam int CODE_W       = 6;
    localparam int DEF_DEPTH    = 8;
    localparam int DEF_FILT_LEN = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_QUAL,
        ST_CAPTURE,
        ST_WAIT_HIGH
    } state_t;

    // code = row*NUM_COLS + col; out-of-range columns (5..7) fold onto the
    // last column so every code stays within 0..39.
    function automatic logic [CODE_W-1:0] key_code(input logic [2:0] row,
                                                   input logic [2:0] col);
        logic [2:0] c;
        c = (col > 3'(NUM_COLS-1)) ? 3'(NUM_COLS-1) : col;
        return CODE_W'(row) * CODE_W'(NUM_COLS) + CODE_W'(c);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with show-ahead read data.
//   CLK, RST  - clock, synchronous active-high reset
//   wr_en     - push request (accepted when not full, or when popping)
//   wr_data   - push data
//   rd_en     - pop request (ignored when empty)
//   rd_data   - entry at the head, valid whenever !empty
//   count     - number of stored entries, 0..DEPTH
//   full      - count == DEPTH
//   empty     - count == 0
module sync_fifo
    import vkey_pkg::*;
#(
    parameter  int W     = CODE_W,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_rd;
    logic          do_wr;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign rd_data = mem[rd_ptr];

    // A pop frees the slot in the same cycle, so a full FIFO still takes a
    // simultaneous push (the old head is read out before it is overwritten).
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end

    always_ff @(posedge CLK) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/vkey_reader.sv
// vkey_reader: turns key-scanner interrupts into a queue of key codes.
//   CLK       - system clock
//   RST       - synchronous active-high reset
//   INT       - scanner interrupt, active low, asynchronous
//   VKEY      - scanner key word: [2:0] row, [6:4] column
//   KEY_RD    - host pop request
//   OVF_CLR   - clears the sticky overflow flag
//   KEY_CODE  - code at the FIFO head, 0 when empty
//   KEY_VALID - FIFO not empty
//   KEY_CNT   - stored entries, 0..DEPTH
//   OVF       - sticky: a key event was dropped on a full FIFO
module vkey_reader
    import vkey_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int FILT_LEN = DEF_FILT_LEN
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              INT,
    input  logic [15:0]       VKEY,
    input  logic              KEY_RD,
    input  logic              OVF_CLR,
    output logic [CODE_W-1:0] KEY_CODE,
    output logic              KEY_VALID,
    output logic [4:0]        KEY_CNT,
    output logic              OVF
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]        sync;
    logic [1:0]        sync_vld;
    logic              int_s;
    state_t            state;
    logic [3:0]        filt_cnt;

    logic              push;
    logic              pop;
    logic [CODE_W-1:0] push_code;
    logic [CODE_W-1:0] head;
    logic [CW-1:0]     fifo_cnt;
    logic              fifo_full;
    logic              fifo_empty;

    // Only row and column bits carry meaning.
    logic              unused_vkey;
    assign unused_vkey = ^{VKEY[15:7], VKEY[3]};

    assign int_s = sync[1];

    // ------------------------------------------------------------------
    // Synchronizer + event qualifier
    // ------------------------------------------------------------------
    // The synchronizer resets high, which looks like a released INT. sync_vld
    // keeps WAIT_HIGH from trusting it until both flops hold real samples, so
    // an INT already low at reset release cannot be mistaken for a new press.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync     <= 2'b11;
            sync_vld <= 2'b00;
            state    <= ST_WAIT_HIGH;
            filt_cnt <= '0;
        end else begin
            sync     <= {sync[0], INT};
            sync_vld <= {sync_vld[0], 1'b1};
            case (state)
                ST_IDLE: begin
                    if (!int_s) begin
                        state    <= ST_QUAL;
                        filt_cnt <= 4'd1;
                    end
                end
                ST_QUAL: begin
                    if (int_s)
                        state <= ST_IDLE;
                    else if (filt_cnt == 4'(FILT_LEN))
                        state <= ST_CAPTURE;
                    else
                        filt_cnt <= filt_cnt + 4'd1;
                end
                ST_CAPTURE: state <= ST_WAIT_HIGH;
                ST_WAIT_HIGH: begin
                    if (int_s && sync_vld[1]) state <= ST_IDLE;
                end
                default: state <= ST_WAIT_HIGH;
            endcase
        end
    end

    // One push per qualified assertion: CAPTURE is a single-cycle state.
    assign push      = (state == ST_CAPTURE);
    assign push_code = key_code(VKEY[2:0], VKEY[6:4]);
    assign pop       = KEY_RD && !fifo_empty;

    // ------------------------------------------------------------------
    // Key-event FIFO
    // ------------------------------------------------------------------
    sync_fifo #(
        .W     (CODE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .wr_en   (push),
        .wr_data (push_code),
        .rd_en   (pop),
        .rd_data (head),
        .count   (fifo_cnt),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // A push lost to a full FIFO beats a clear in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST)
            OVF <= 1'b0;
        else if (push && fifo_full && !pop)
            OVF <= 1'b1;
        else if (OVF_CLR)
            OVF <= 1'b0;
    end

    assign KEY_VALID = !fifo_empty;
    assign KEY_CODE  = fifo_empty ? '0 : head;
    assign KEY_CNT   = 5'(fifo_cnt);

endmodule
